// File: rtl/hack_pkg.sv
// Shared definitions for the XOR frame checksum block: FSM state encoding
// and the default data word width.
package hack_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/xor_frame_checksum_xor_n.sv
// Parametrised WIDTH-bit bitwise XOR used as the checksum accumulate datapath.
module xor_n #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign y[gi] = a[gi] ^ b[gi];
        end
    endgenerate

endmodule

// File: rtl/xor_frame_checksum.sv
// Per-frame XOR checksum with saturating beat count and overflow flag.
// Optional out_parity port is enabled by defining XOR_FRAME_PARITY_EN.
module xor_frame_checksum
    import hack_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MAX_WORDS = 256,
    localparam int CW       = $clog2(MAX_WORDS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [CW-1:0]    out_count,
    output logic             out_overflow
`ifdef XOR_FRAME_PARITY_EN
    ,
    output logic             out_parity
`endif
);

    state_t           state_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [CW-1:0]    count_reg;
    logic             ovf_reg;

    logic             accept;
    logic             sat;
    logic [WIDTH-1:0] acc_base;
    logic [WIDTH-1:0] acc_next;
    logic [CW-1:0]    count_next;
    logic             ovf_next;

    assign in_ready  = (state_reg != DONE);
    assign out_valid = (state_reg == DONE);
    assign accept    = in_valid && in_ready;

    assign sat        = (count_reg == CW'(MAX_WORDS));
    assign count_next = sat ? count_reg : count_reg + CW'(1);
    assign ovf_next   = ovf_reg | sat;

    // First beat of a frame loads the word rather than folding in stale state.
    assign acc_base = (state_reg == IDLE) ? '0 : acc_reg;

    xor_n #(
        .WIDTH(WIDTH)
    ) u_xor (
        .a(acc_base),
        .b(in_data),
        .y(acc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            count_reg <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc_reg   <= acc_next;
                        count_reg <= count_next;
                        ovf_reg   <= ovf_next;
                        state_reg <= in_last ? DONE : ACCUM;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        acc_reg   <= '0;
                        count_reg <= '0;
                        ovf_reg   <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    acc_reg   <= '0;
                    count_reg <= '0;
                    ovf_reg   <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign out_sum      = acc_reg;
    assign out_count    = count_reg;
    assign out_overflow = ovf_reg;

`ifdef XOR_FRAME_PARITY_EN
    assign out_parity = ^acc_reg;
`endif

endmodule

// File: tb/tb_xor_frame_checksum.sv
// Scoreboard bench for xor_frame_checksum (WIDTH=16, MAX_WORDS=4); checks
// out_parity as well when XOR_FRAME_PARITY_EN is defined.
module tb_xor_frame_checksum;

    localparam int WIDTH     = 16;
    localparam int MAX_WORDS = 4;
    localparam int CW        = $clog2(MAX_WORDS + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_sum;
    logic [CW-1:0]    out_count;
    logic             out_overflow;
`ifdef XOR_FRAME_PARITY_EN
    logic             out_parity;
`endif

    xor_frame_checksum #(
        .WIDTH(WIDTH),
        .MAX_WORDS(MAX_WORDS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_last(in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum(out_sum),
        .out_count(out_count),
        .out_overflow(out_overflow)
`ifdef XOR_FRAME_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic [CW-1:0]    cnt;
        logic             ovf;
    } exp_t;

    exp_t             sb_q[$];
    logic [WIDTH-1:0] frame_q[$];
    int               total = 0;
    int               bad = 0;
    int               frames_seen = 0;
    int               frames_sent = 0;
    bit               rand_ready = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model for the frame currently held in frame_q.
    function automatic exp_t model();
        exp_t e;
        int   n;
        e.sum = '0;
        n = frame_q.size();
        for (int i = 0; i < n; i++) e.sum = e.sum ^ frame_q[i];
        e.cnt = CW'((n > MAX_WORDS) ? MAX_WORDS : n);
        e.ovf = (n > MAX_WORDS);
        return e;
    endfunction

    task automatic push_expected();
        sb_q.push_back(model());
        frames_sent++;
    endtask

    // Called from posedge+1; returns at posedge+1 after the final beat is accepted.
    task automatic send_frame(input bit has_last, input int gap);
        bit acc;
        int wait_cnt;
        for (int i = 0; i < frame_q.size(); i++) begin
            while (gap > 0 && $urandom_range(0, 99) < gap) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = frame_q[i];
            in_last  = has_last && (i == frame_q.size() - 1);
            acc      = 1'b0;
            wait_cnt = 0;
            while (!acc && wait_cnt < 200) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk);
                #1;
                wait_cnt++;
            end
            if (!acc) begin
                chk("accept_timeout", 64'(0), 64'(1));
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 1) == 1);
        end
    end

    // Result monitor: compares every released frame against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_result", 64'(1), 64'(0));
                end else begin
                    e = sb_q.pop_front();
                    $display("frame %0d sum=%04h count=%0d ovf=%0b (exp %04h/%0d/%0b)",
                             frames_seen, out_sum, out_count, out_overflow, e.sum, e.cnt, e.ovf);
                    chk("sb_sum", 64'(out_sum), 64'(e.sum));
                    chk("sb_count", 64'(out_count), 64'(e.cnt));
                    chk("sb_overflow", 64'(out_overflow), 64'(e.ovf));
`ifdef XOR_FRAME_PARITY_EN
                    chk("sb_parity", 64'(out_parity), 64'(^e.sum));
`endif
                end
                frames_seen++;
            end
        end
    end

    initial begin
        int n;
        int drain;

        // Reset state before any clock edge
        #2;
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_sum", 64'(out_sum), 64'(0));
        chk("rst_count", 64'(out_count), 64'(0));
        chk("rst_overflow", 64'(out_overflow), 64'(0));
`ifdef XOR_FRAME_PARITY_EN
        chk("rst_parity", 64'(out_parity), 64'(0));
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_ready", 64'(in_ready), 64'(1));

        // Three-beat frame, 1-cycle result latency
        out_ready = 1'b1;
        frame_q = '{16'h00FF, 16'h0F0F, 16'hFFFF};
        push_expected();
        send_frame(1'b1, 0);
        @(negedge clk);
        chk("lat_valid", 64'(out_valid), 64'(1));
        chk("lat_sum", 64'(out_sum), 64'(16'hF00F));
        chk("lat_count", 64'(out_count), 64'(3));
        @(posedge clk);
        #1;
        chk("idle_sum_clear", 64'(out_sum), 64'(0));
        chk("idle_count_clear", 64'(out_count), 64'(0));
        chk("idle_valid", 64'(out_valid), 64'(0));

        // Single-beat frame
        frame_q = '{16'hA5A5};
        push_expected();
        send_frame(1'b1, 0);
        @(negedge clk);
        chk("one_sum", 64'(out_sum), 64'(16'hA5A5));
        chk("one_count", 64'(out_count), 64'(1));
`ifdef XOR_FRAME_PARITY_EN
        chk("one_parity", 64'(out_parity), 64'(0));
`endif
        @(posedge clk);
        #1;

        // Hold in DONE with a beat pending on the input
        out_ready = 1'b0;
        frame_q = '{16'h1111, 16'h2222};
        push_expected();
        send_frame(1'b1, 0);
        in_valid = 1'b1;
        in_data  = 16'hBEEF;
        in_last  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("hold_ready", 64'(in_ready), 64'(0));
            chk("hold_valid", 64'(out_valid), 64'(1));
            chk("hold_sum", 64'(out_sum), 64'(16'h3333));
            chk("hold_count", 64'(out_count), 64'(2));
            chk("hold_overflow", 64'(out_overflow), 64'(0));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_valid", 64'(out_valid), 64'(0));
        chk("release_sum", 64'(out_sum), 64'(0));
        chk("release_count", 64'(out_count), 64'(0));
        chk("release_ready", 64'(in_ready), 64'(1));
        frame_q = '{16'hBEEF};
        push_expected();
        send_frame(1'b1, 0);
        @(negedge clk);
        chk("held_beat_sum", 64'(out_sum), 64'(16'hBEEF));
        chk("held_beat_count", 64'(out_count), 64'(1));
        @(posedge clk);
        #1;

        // Saturation: six beats with MAX_WORDS=4
        frame_q = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001};
        push_expected();
        send_frame(1'b1, 0);
        @(negedge clk);
        chk("sat_count", 64'(out_count), 64'(4));
        chk("sat_overflow", 64'(out_overflow), 64'(1));
        chk("sat_sum", 64'(out_sum), 64'(0));
        @(posedge clk);
        #1;

        // Asynchronous reset mid-frame discards the partial result
        frame_q = '{16'h0011, 16'h0022};
        send_frame(1'b0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_sum", 64'(out_sum), 64'(0));
        chk("mid_rst_count", 64'(out_count), 64'(0));
        chk("mid_rst_overflow", 64'(out_overflow), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        frame_q = '{16'h1234};
        push_expected();
        send_frame(1'b1, 0);
        @(negedge clk);
        chk("post_rst_sum", 64'(out_sum), 64'(16'h1234));
        chk("post_rst_count", 64'(out_count), 64'(1));
        @(posedge clk);
        #1;

        // Random frames with backpressure on both sides
        rand_ready = 1'b1;
        for (int f = 0; f < 1000; f++) begin
            n = $urandom_range(1, 8);
            frame_q.delete();
            for (int i = 0; i < n; i++) frame_q.push_back(WIDTH'($urandom));
            push_expected();
            send_frame(1'b1, 30);
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain = 0;
        while (sb_q.size() != 0 && drain < 50) begin
            @(posedge clk);
            #1;
            drain++;
        end
        chk("drain_empty", 64'(sb_q.size()), 64'(0));
        chk("frames_seen", 64'(frames_seen), 64'(frames_sent));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xor_frame_checksum.md
XOR_FRAME_CHECKSUM -- requirements
Module: xor_frame_checksum

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits; SHALL be legal for 1..64.
REQ-002 Parameter MAX_WORDS, default 256, count saturation limit; SHALL be legal for 1..65535.
REQ-003 Derived CW = $clog2(MAX_WORDS+1), width of the count port.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-006 in_valid  in  1  input beat offered.
REQ-007 in_ready  out  1  block can accept an input beat.
REQ-008 in_data  in  WIDTH  input word.
REQ-009 in_last  in  1  offered beat is the last of its frame.
REQ-010 out_valid  out  1  frame result held.
REQ-011 out_ready  in  1  downstream accepts the result.
REQ-012 out_sum  out  WIDTH  bitwise XOR of all accepted words of the frame.
REQ-013 out_count  out  CW  accepted beats in the frame, saturating at MAX_WORDS.
REQ-014 out_overflow  out  1  frame exceeded MAX_WORDS beats.

Function
REQ-015 A beat SHALL be accepted only in a cycle where in_valid=1 and in_ready=1.
REQ-016 FSM states SHALL be IDLE, ACCUM and DONE.
REQ-017 in_ready SHALL be 1 in IDLE and ACCUM, 0 in DONE, decoded from the state register only.
REQ-018 out_valid SHALL be 1 exactly when the state is DONE.
REQ-019 IDLE: accept, no last -> ACCUM; accept with last -> DONE; otherwise stay in IDLE.
REQ-020 ACCUM: accept with last -> DONE; otherwise stay in ACCUM.
REQ-021 DONE: out_ready=1 -> IDLE; otherwise hold DONE with all outputs stable.
REQ-022 The accumulator SHALL load in_data on the first accepted beat of a frame and XOR in each subsequent accepted beat.
REQ-023 out_valid SHALL assert in the cycle after the last beat is accepted (1-cycle latency).
REQ-024 A 1-beat frame SHALL give out_sum=in_data and out_count=1.
REQ-025 out_count SHALL increment per accepted beat and saturate at MAX_WORDS.
REQ-026 out_overflow SHALL set on any accepted beat while the count is already at MAX_WORDS, and hold until the frame is released.
REQ-027 The accumulator SHALL keep accumulating past saturation; only the count saturates.
REQ-028 The DONE->IDLE handshake cycle SHALL clear accumulator, count and overflow, so they read 0 in IDLE.
REQ-029 Beats offered while in DONE SHALL NOT be accepted or lost; the source holds them until in_ready returns.
REQ-030 No beat SHALL be accepted in the DONE->IDLE handshake cycle itself (in_ready=0 there).

Reset
REQ-031 Asserting rst_n low SHALL force IDLE, out_valid=0, out_sum=0, out_count=0 and out_overflow=0, independent of clk.
REQ-032 Reset mid-frame or in DONE SHALL discard the partial or held result with no output.
REQ-033 Once rst_n deasserts, in_ready SHALL be 1 from the first clock edge.

Configuration
REQ-034 Macro XOR_FRAME_PARITY_EN defined: adds out_parity (out, 1) = XOR-reduction of out_sum, valid with out_valid and 0 at reset.
REQ-035 Macro XOR_FRAME_PARITY_EN undefined: the out_parity port and its logic SHALL be absent; all other behaviour is unchanged.

Structure
REQ-036 The FSM state enum (IDLE, ACCUM, DONE) and default WIDTH=16 SHALL live in shared package hack_pkg.
REQ-037 One sub-module, xor_n (parametrised WIDTH-bit bitwise XOR), SHALL implement the accumulate datapath.

Verification
REQ-038 WIDTH=16: beats 0x00FF, 0x0F0F, 0xFFFF(last), out_ready=1 -> out_valid 1 cycle after last, out_sum=0xF00F, out_count=3.
REQ-039 Single beat 0xA5A5 with last -> out_sum=0xA5A5, out_count=1; with macro, out_parity=0.
REQ-040 Hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> in_ready=0, outputs stable, no beat accepted; release -> next frame starts clean.
REQ-041 MAX_WORDS=4, frame of 6 beats of 0x0001 -> out_count=4, out_overflow=1, out_sum=0x0000.
REQ-042 Assert rst_n=0 after 2 of 4 beats -> all outputs 0 at once; a following 1-beat frame 0x1234 gives out_sum=0x1234, out_count=1.
REQ-043 Random in_valid/out_ready backpressure over 1000 frames -> out_sum and out_count match the reference model every frame.
